ysyx_25050147_ctrl: RTL and testbench
=====================================

YSYX_25050147_CTRL -- requirements
Module: ysyx_25050147_CTRL

Interface
REQ-001 SHALL have parameter: TIMEOUT_CYCLES, 255, response-wait limit in cycles (legal range 1..255).
REQ-002 SHALL have port: clk  in  1  sole clock; all state changes on rising edge.
REQ-003 SHALL have port: rst  in  1  synchronous, active-high reset.
REQ-004 SHALL have port: ifu_req_valid  out  1  instruction fetch request.
REQ-005 SHALL have port: ifu_req_ready  in  1  fetch request accepted.
REQ-006 SHALL have port: ifu_resp_valid  in  1  instruction word valid.
REQ-007 SHALL have port: inst_we  out  1  load the instruction register feeding the decoder.
REQ-008 SHALL have port: op_type  in  5  decoder class; 0=EBREAK, 1=JUMP, 2=ELSE, 4=STORE, 8=LOAD, 16=BRANCH.
REQ-009 SHALL have port: br_taken  in  1  branch condition from the ALU.
REQ-010 SHALL have port: pc_we  out  1  PC update strobe.
REQ-011 SHALL have port: pc_sel  out  2  00=pc+4, 01=jump target, 10=branch target.
REQ-012 SHALL have port: rf_we  out  1  register-file write strobe.
REQ-013 SHALL have ports: lsu_req_valid out 1, lsu_req_wen out 1 (1=store), lsu_req_ready in 1, lsu_resp_valid in 1.
REQ-014 SHALL have ports: halt out 1 (sticky stop), err out 1 (timeout error), instret out 32 (retired-instruction count).

Function
REQ-015 SHALL implement states FETCH, IWAIT, EXEC, MREQ, MWAIT, HALT, plus ERR (only when the configuration macro is defined).
REQ-016 FETCH: ifu_req_valid=1; SHALL go to IWAIT when ifu_req_ready=1, else stay.
REQ-017 IWAIT: SHALL assert inst_we for exactly the cycle ifu_resp_valid=1, then go to EXEC; ifu_resp_valid SHALL be ignored in every other state.
REQ-018 EXEC (one cycle): SHALL capture op_type into an internal register and act on it in that same cycle.
REQ-019 EXEC, ELSE: rf_we=1, pc_we=1, pc_sel=00, then FETCH.
REQ-020 EXEC, JUMP: rf_we=1, pc_we=1, pc_sel=01, then FETCH.
REQ-021 EXEC, BRANCH: pc_we=1, rf_we=0, pc_sel=10 if br_taken else 00, then FETCH.
REQ-022 EXEC, LOAD or STORE: no strobes; SHALL go to MREQ.
REQ-023 EXEC, EBREAK: no strobes; SHALL go to HALT.
REQ-024 EXEC, any other op_type value (not one-hot, not zero): pc_we=1, pc_sel=00, rf_we=0, then FETCH.
REQ-025 MREQ: lsu_req_valid=1, lsu_req_wen=(captured op is STORE), both held stable until lsu_req_ready=1; SHALL then go to MWAIT.
REQ-026 MWAIT: on lsu_resp_valid=1, SHALL assert pc_we=1 and pc_sel=00, assert rf_we=1 for LOAD only, then go to FETCH.
REQ-027 pc_we, rf_we and inst_we SHALL each be single-cycle pulses; pc_sel SHALL be 00 whenever pc_we=0.
REQ-028 instret SHALL increment by 1 on every cycle with pc_we=1 and wrap from 0xFFFFFFFF to 0.
REQ-029 HALT: all request and strobe outputs SHALL be 0, halt=1, and the state SHALL persist until rst.
REQ-030 Minimum latency SHALL be 3 cycles per ELSE/JUMP/BRANCH instruction and 5 cycles per LOAD/STORE, with ready and responses arriving on the first eligible cycle.

Reset
REQ-031 While rst=1: state=FETCH, instret=0, halt=0, err=0, the timeout counter clears, and every request and strobe output is 0, including ifu_req_valid.
REQ-032 rst SHALL take priority over all events in any state, including mid-handshake in MREQ or MWAIT, with no strobe emitted that cycle.

Configuration
REQ-033 Macro YSYX_25050147_CTRL_TIMEOUT_EN defined: an 8-bit counter SHALL clear on entry to IWAIT or MWAIT and increment each waiting cycle. When the count reaches TIMEOUT_CYCLES with no response, the block SHALL enter ERR, where halt=1, err=1 and all strobes are 0 until rst. A response arriving on the same cycle as the limit SHALL win.
REQ-034 Macro undefined: the counter and the ERR state SHALL be absent, waits SHALL be unbounded, and err SHALL be tied to 0.

Verification
REQ-035 Reset, then an ELSE instruction with ready and response immediate: rf_we and pc_we pulse together in cycle 3, pc_sel=00, instret=1.
REQ-036 BRANCH with br_taken=1: pc_sel=10 and rf_we=0; with br_taken=0: pc_sel=00.
REQ-037 LOAD with lsu_req_ready held low 4 cycles: lsu_req_valid and lsu_req_wen=0 stay stable; after the response, rf_we=1 once.
REQ-038 EBREAK: halt=1 from the next cycle; further ifu_req_ready and ifu_resp_valid pulses produce no output until rst.
REQ-039 With the macro defined and TIMEOUT_CYCLES=4, withhold ifu_resp_valid: err=1 and halt=1 after 4 waiting cycles. With the macro undefined, the block is still in IWAIT after 1000 cycles.
REQ-040 Force instret to 0xFFFFFFFF via 2^32-1 retirements or a backdoor, then retire one instruction: instret=0.

Source files
------------

// File: rtl/ysyx_25050147_ctrl.sv
// ysyx_25050147_ctrl: multi-cycle control FSM for a single-issue core.
// Sequences fetch -> decode/execute -> optional memory access and emits the
// PC / register-file / instruction-register strobes plus a retired counter.
// Optional macro YSYX_25050147_CTRL_TIMEOUT_EN adds a response-wait watchdog
// that parks the block in an error state when a response never arrives.
module ysyx_25050147_ctrl #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    output logic        ifu_req_valid,
    input  logic        ifu_req_ready,
    input  logic        ifu_resp_valid,
    output logic        inst_we,
    input  logic [4:0]  op_type,
    input  logic        br_taken,
    output logic        pc_we,
    output logic [1:0]  pc_sel,
    output logic        rf_we,
    output logic        lsu_req_valid,
    output logic        lsu_req_wen,
    input  logic        lsu_req_ready,
    input  logic        lsu_resp_valid,
    output logic        halt,
    output logic        err,
    output logic [31:0] instret
);

    localparam logic [4:0] OP_EBREAK = 5'd0;
    localparam logic [4:0] OP_JUMP   = 5'd1;
    localparam logic [4:0] OP_ELSE   = 5'd2;
    localparam logic [4:0] OP_STORE  = 5'd4;
    localparam logic [4:0] OP_LOAD   = 5'd8;
    localparam logic [4:0] OP_BRANCH = 5'd16;

    // Reject configurations the 8-bit wait counter cannot represent.
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be within 1..255");
    end

    typedef enum logic [2:0] {
        S_FETCH,
        S_IWAIT,
        S_EXEC,
        S_MREQ,
        S_MWAIT,
        S_HALT
`ifdef YSYX_25050147_CTRL_TIMEOUT_EN
        , S_ERR
`endif
    } state_t;

    state_t      state, state_nxt;
    logic [4:0]  op_q;
    logic [31:0] instret_q;

`ifdef YSYX_25050147_CTRL_TIMEOUT_EN
    localparam logic [8:0] TO_LIM = 9'(TIMEOUT_CYCLES);
    logic [7:0] to_cnt;
    logic       to_hit;

    // Limit reached when this waiting cycle is the TIMEOUT_CYCLES-th one.
    assign to_hit = ({1'b0, to_cnt} + 9'd1) >= TO_LIM;

    // Wait counter: cleared on entering a wait state, counts idle wait cycles.
    always_ff @(posedge clk) begin
        if (rst)
            to_cnt <= 8'd0;
        else if (state_nxt != state && (state_nxt == S_IWAIT || state_nxt == S_MWAIT))
            to_cnt <= 8'd0;
        else if (state == S_IWAIT || state == S_MWAIT)
            to_cnt <= to_cnt + 8'd1;
    end
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= S_FETCH;
        else     state <= state_nxt;
    end

    // Capture the decoded class in EXEC so the memory phase knows load vs store.
    always_ff @(posedge clk) begin
        if (rst)                 op_q <= OP_EBREAK;
        else if (state == S_EXEC) op_q <= op_type;
    end

    // Retired-instruction counter, one per PC update; wraps naturally.
    always_ff @(posedge clk) begin
        if (rst)        instret_q <= 32'd0;
        else if (pc_we) instret_q <= instret_q + 32'd1;
    end

    assign instret = instret_q;

    // Next-state and strobes; everything forced low while rst is high.
    always_comb begin
        state_nxt     = state;
        ifu_req_valid = 1'b0;
        inst_we       = 1'b0;
        pc_we         = 1'b0;
        pc_sel        = 2'b00;
        rf_we         = 1'b0;
        lsu_req_valid = 1'b0;
        lsu_req_wen   = 1'b0;
        halt          = 1'b0;
        err           = 1'b0;
        if (!rst) begin
            case (state)
                S_FETCH: begin
                    ifu_req_valid = 1'b1;
                    if (ifu_req_ready) state_nxt = S_IWAIT;
                end
                S_IWAIT: begin
                    if (ifu_resp_valid) begin
                        inst_we   = 1'b1;
                        state_nxt = S_EXEC;
                    end
`ifdef YSYX_25050147_CTRL_TIMEOUT_EN
                    else if (to_hit) state_nxt = S_ERR;
`endif
                end
                S_EXEC: begin
                    state_nxt = S_FETCH;
                    case (op_type)
                        OP_ELSE: begin
                            rf_we = 1'b1;
                            pc_we = 1'b1;
                        end
                        OP_JUMP: begin
                            rf_we  = 1'b1;
                            pc_we  = 1'b1;
                            pc_sel = 2'b01;
                        end
                        OP_BRANCH: begin
                            pc_we  = 1'b1;
                            pc_sel = br_taken ? 2'b10 : 2'b00;
                        end
                        OP_LOAD, OP_STORE: state_nxt = S_MREQ;
                        OP_EBREAK:         state_nxt = S_HALT;
                        // Unknown encodings retire as a plain PC+4.
                        default:           pc_we = 1'b1;
                    endcase
                end
                S_MREQ: begin
                    lsu_req_valid = 1'b1;
                    lsu_req_wen   = (op_q == OP_STORE);
                    if (lsu_req_ready) state_nxt = S_MWAIT;
                end
                S_MWAIT: begin
                    if (lsu_resp_valid) begin
                        pc_we     = 1'b1;
                        rf_we     = (op_q == OP_LOAD);
                        state_nxt = S_FETCH;
                    end
`ifdef YSYX_25050147_CTRL_TIMEOUT_EN
                    else if (to_hit) state_nxt = S_ERR;
`endif
                end
                S_HALT: halt = 1'b1;
`ifdef YSYX_25050147_CTRL_TIMEOUT_EN
                S_ERR: begin
                    halt = 1'b1;
                    err  = 1'b1;
                end
`endif
                default: state_nxt = S_FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_25050147_ctrl.sv
// Scoreboard bench for ysyx_25050147_ctrl: every retirement the driver causes
// pushes the expected {pc_sel, rf_we, instret} and the monitor pops it on pc_we.
module tb_ysyx_25050147_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ifu_req_valid, ifu_req_ready = 0, ifu_resp_valid = 0, inst_we;
    logic [4:0]  op_type = 5'd2;
    logic        br_taken = 0;
    logic        pc_we, rf_we;
    logic [1:0]  pc_sel;
    logic        lsu_req_valid, lsu_req_wen, lsu_req_ready = 0, lsu_resp_valid = 0;
    logic        halt, err;
    logic [31:0] instret;

    localparam logic [4:0] EBREAK = 5'd0, JUMP = 5'd1, ELSE_ = 5'd2,
                           STORE = 5'd4, LOAD = 5'd8, BRANCH = 5'd16;

    ysyx_25050147_ctrl #(.TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .rst(rst),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready),
        .ifu_resp_valid(ifu_resp_valid), .inst_we(inst_we),
        .op_type(op_type), .br_taken(br_taken),
        .pc_we(pc_we), .pc_sel(pc_sel), .rf_we(rf_we),
        .lsu_req_valid(lsu_req_valid), .lsu_req_wen(lsu_req_wen),
        .lsu_req_ready(lsu_req_ready), .lsu_resp_valid(lsu_resp_valid),
        .halt(halt), .err(err), .instret(instret)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]  sel;
        logic        rf;
        logic [31:0] cnt;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] model_cnt = 32'd0;
    int          total = 0, bad = 0;
    logic [4:0]  op_tbl [0:6] = '{ELSE_, JUMP, BRANCH, LOAD, STORE, 5'd3, 5'd17};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [1:0] sel, input logic rf);
        exp_t e;
        e.sel = sel;
        e.rf  = rf;
        e.cnt = model_cnt;
        sb.push_back(e);
        model_cnt = model_cnt + 32'd1;
    endtask

    // Monitor: pop on each PC update; pc_sel must idle at 00 otherwise.
    always @(negedge clk) begin
        exp_t e;
        if (pc_we) begin
            if (sb.size() == 0) chk("unexpected_pc_we", 1, 0);
            else begin
                e = sb.pop_front();
                chk("pc_sel", {30'd0, pc_sel}, {30'd0, e.sel});
                chk("rf_we", {31'd0, rf_we}, {31'd0, e.rf});
                chk("instret_pre", instret, e.cnt);
            end
        end else begin
            chk("pc_sel_idle", {30'd0, pc_sel}, 32'd0);
        end
    end

    task automatic do_reset();
        rst = 1; ifu_req_ready = 0; ifu_resp_valid = 0;
        lsu_req_ready = 0; lsu_resp_valid = 0;
        @(negedge clk);
        chk("rst_outs", {24'd0, ifu_req_valid, inst_we, pc_we, rf_we,
                         lsu_req_valid, lsu_req_wen, halt, err}, 32'd0);
        cyc();
        @(negedge clk);
        chk("rst_instret", instret, 32'd0);
        cyc();
        rst = 0;
        model_cnt = 32'd0;
    endtask

    // Drives one instruction starting in FETCH; ready/responses immediate
    // unless delayed. With mid_rst, rst hits in MWAIT together with the response.
    task automatic run_op(input logic [4:0] op, input logic br,
                          input int rdy_dly, input int resp_dly, input logic mid_rst);
        logic mem, exec_ret;
        mem      = (op == LOAD) || (op == STORE);
        exec_ret = !mem && (op != EBREAK);
        ifu_req_ready = 1;
        @(negedge clk);
        chk("ifu_req_valid", {31'd0, ifu_req_valid}, 1);
        cyc();
        ifu_req_ready = 0; ifu_resp_valid = 1; op_type = op; br_taken = br;
        @(negedge clk);
        chk("inst_we", {31'd0, inst_we}, 1);
        cyc();
        ifu_resp_valid = 0;
        if (exec_ret) begin
            case (op)
                ELSE_:   push_exp(2'b00, 1);
                JUMP:    push_exp(2'b01, 1);
                BRANCH:  push_exp(br ? 2'b10 : 2'b00, 0);
                default: push_exp(2'b00, 0);
            endcase
        end
        @(negedge clk);
        chk("exec_pc_we", {31'd0, pc_we}, {31'd0, exec_ret});
        chk("exec_inst_we", {31'd0, inst_we}, 0);
        cyc();
        op_type = 5'h1f;   // decoder moves on; memory phase must use the captured op
        if (mem) begin
            for (int i = 0; i < rdy_dly; i++) begin
                @(negedge clk);
                chk("mreq_hold", {30'd0, lsu_req_valid, lsu_req_wen}, {30'd0, 1'b1, op == STORE});
                cyc();
            end
            lsu_req_ready = 1;
            @(negedge clk);
            chk("mreq", {30'd0, lsu_req_valid, lsu_req_wen}, {30'd0, 1'b1, op == STORE});
            cyc();
            lsu_req_ready = 0;
            for (int i = 0; i < resp_dly; i++) begin
                @(negedge clk);
                chk("mwait_idle", {30'd0, pc_we, rf_we}, 0);
                cyc();
            end
            lsu_resp_valid = 1;
            if (mid_rst) rst = 1;
            else push_exp(2'b00, op == LOAD);
            @(negedge clk);
            chk("mwait_pc_we", {31'd0, pc_we}, {31'd0, !mid_rst});
            cyc();
            lsu_resp_valid = 0;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset();
        run_op(ELSE_, 0, 0, 0, 0);
        @(negedge clk); chk("instret_after_else", instret, 1);
        cyc();
        run_op(JUMP, 0, 0, 0, 0);
        run_op(BRANCH, 1, 0, 0, 0);
        run_op(BRANCH, 0, 0, 0, 0);
        run_op(5'd3, 1, 0, 0, 0);
        run_op(5'd24, 0, 0, 0, 0);
        run_op(LOAD, 0, 4, 0, 0);
        run_op(STORE, 0, 0, 2, 0);
        run_op(LOAD, 0, 0, 0, 0);
        @(negedge clk); chk("instret_seq", instret, model_cnt);
        cyc();

        // Fetch response withheld.
        ifu_req_ready = 1;
        cyc();
        ifu_req_ready = 0;
`ifdef YSYX_25050147_CTRL_TIMEOUT_EN
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); chk("wait_no_err", {30'd0, err, halt}, 0);
            cyc();
        end
        @(negedge clk); chk("timeout", {30'd0, err, halt}, 32'd3);
        cyc();
`else
        repeat (1000) cyc();
        @(negedge clk);
        chk("still_iwait", {28'd0, ifu_req_valid, inst_we, err, halt}, 0);
        cyc();
        ifu_resp_valid = 1; op_type = ELSE_;
        @(negedge clk); chk("late_inst_we", {31'd0, inst_we}, 1);
        cyc();
        ifu_resp_valid = 0;
        push_exp(2'b00, 1);
        @(negedge clk); chk("late_pc_we", {31'd0, pc_we}, 1);
        cyc();
`endif
        do_reset();

        for (int n = 0; n < 20; n++)
            run_op(op_tbl[$urandom_range(0, 6)], 1'($urandom_range(0, 1)),
                   $urandom_range(0, 3), $urandom_range(0, 3), 0);

        // Counter wrap via backdoor preload.
        force dut.instret_q = 32'hFFFF_FFFF;
        @(negedge clk);
        release dut.instret_q;
        model_cnt = 32'hFFFF_FFFF;
        cyc();
        run_op(ELSE_, 0, 0, 0, 0);
        @(negedge clk); chk("instret_wrap", instret, 32'd0);
        cyc();

        // Reset lands mid-handshake in MWAIT together with the response.
        run_op(LOAD, 0, 1, 1, 1);
        do_reset();

        // EBREAK then ignored fetch traffic.
        run_op(ELSE_, 0, 0, 0, 0);
        run_op(EBREAK, 0, 0, 0, 0);
        @(negedge clk); chk("halt", {30'd0, halt, err}, 32'd2);
        cyc();
        ifu_req_ready = 1; ifu_resp_valid = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("halt_quiet", {27'd0, ifu_req_valid, inst_we, lsu_req_valid, rf_we, halt}, 1);
            cyc();
        end
        @(negedge clk); chk("halt_instret", instret, 32'd1);
        do_reset();

        run_op(JUMP, 0, 0, 0, 0);
        repeat (2) cyc();
        chk("sb_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
